// File: rtl/sram_arb_ctrl.sv
// Round-robin arbiter and access sequencer for an SR-latch SRAM array.
// Guards setup/hold so RW and Din only move while no row is selected.
module sram_arb_ctrl #(
  parameter int AW        = 3,
  parameter int DW        = 8,
  parameter int WR_CYCLES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req0,
  input  logic                req1,
  input  logic                we0,
  input  logic                we1,
  input  logic [AW-1:0]       addr0,
  input  logic [AW-1:0]       addr1,
  input  logic [DW-1:0]       wdata0,
  input  logic [DW-1:0]       wdata1,
  output logic                ack0,
  output logic                ack1,
  output logic [DW-1:0]       rdata,
  output logic                busy,
  output logic [(1<<AW)-1:0]  mem_sel,
  output logic                mem_rw,
  output logic [DW-1:0]       mem_din,
  input  logic [DW-1:0]       mem_dout
);

  localparam int DEPTH = 1 << AW;
  localparam int CW    = (WR_CYCLES > 1) ? $clog2(WR_CYCLES) : 1;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    DONE
  } state_t;

  state_t          state_q, state_d;
  logic            gnt_q, gnt_d;
  logic            last_q, last_d;
  logic            we_q, we_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            ack0_q, ack0_d;
  logic            ack1_q, ack1_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic            busy_q, busy_d;
  logic [DEPTH-1:0] mem_sel_q, mem_sel_d;
  logic            mem_rw_q, mem_rw_d;
  logic [DW-1:0]   mem_din_q, mem_din_d;

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    last_d    = last_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    cnt_d     = cnt_q;
    rdata_d   = rdata_q;
    ack0_d    = 1'b0;
    ack1_d    = 1'b0;
    mem_sel_d = '0;
    mem_rw_d  = mem_rw_q;
    mem_din_d = mem_din_q;

    unique case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          // contention goes to whoever was not served last
          gnt_d   = (req0 && req1) ? ~last_q : req1;
          we_d    = gnt_d ? we1    : we0;
          addr_d  = gnt_d ? addr1  : addr0;
          wdata_d = gnt_d ? wdata1 : wdata0;
          state_d = SETUP;
        end
      end
      SETUP: begin
        state_d = ACCESS;
        cnt_d   = CW'(WR_CYCLES - 1);
      end
      ACCESS: begin
        if (!we_q) begin
          rdata_d = mem_dout;
          state_d = DONE;
        end else if (cnt_q == '0) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE: begin
        last_d  = gnt_q;
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);

    // outputs are registered, so they follow the state being entered
    unique case (state_d)
      IDLE: begin
        mem_rw_d  = 1'b1;
        mem_din_d = '0;
      end
      SETUP: begin
        mem_rw_d  = ~we_d;
        mem_din_d = we_d ? wdata_d : '0;
      end
      ACCESS: begin
        mem_sel_d = DEPTH'(1) << addr_d;
      end
      DONE: begin
        ack0_d = ~gnt_d;
        ack1_d = gnt_d;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      gnt_q     <= 1'b0;
      last_q    <= 1'b1;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      cnt_q     <= '0;
      ack0_q    <= 1'b0;
      ack1_q    <= 1'b0;
      rdata_q   <= '0;
      busy_q    <= 1'b0;
      mem_sel_q <= '0;
      mem_rw_q  <= 1'b1;
      mem_din_q <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      last_q    <= last_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      cnt_q     <= cnt_d;
      ack0_q    <= ack0_d;
      ack1_q    <= ack1_d;
      rdata_q   <= rdata_d;
      busy_q    <= busy_d;
      mem_sel_q <= mem_sel_d;
      mem_rw_q  <= mem_rw_d;
      mem_din_q <= mem_din_d;
    end
  end

  assign ack0    = ack0_q;
  assign ack1    = ack1_q;
  assign rdata   = rdata_q;
  assign busy    = busy_q;
  assign mem_sel = mem_sel_q;
  assign mem_rw  = mem_rw_q;
  assign mem_din = mem_din_q;

endmodule

// File: tb/tb_sram_arb_ctrl.sv
// Bench for sram_arb_ctrl: directed table, corner sequences, random batches.
// A latch-array model answers mem_dout; a transaction-level model predicts.
module tb_sram_arb_ctrl;

  localparam int WR = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req0 = 0, req1 = 0, we0 = 0, we1 = 0;
  logic [2:0] addr0 = 0, addr1 = 0;
  logic [7:0] wdata0 = 0, wdata1 = 0;
  logic       ack0, ack1, busy, mem_rw;
  logic [7:0] rdata, mem_sel, mem_din, mem_dout;

  sram_arb_ctrl #(.AW(3), .DW(8), .WR_CYCLES(WR)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata(rdata), .busy(busy),
    .mem_sel(mem_sel), .mem_rw(mem_rw), .mem_din(mem_din),
    .mem_dout(mem_dout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // the cell array: latches follow Din while selected with RW=0
  logic [7:0] arr [8];
  always @(posedge clk)
    for (int i = 0; i < 8; i++)
      if (mem_sel[i] && !mem_rw) arr[i] <= mem_din;
  always_comb begin
    mem_dout = '0;
    for (int i = 0; i < 8; i++)
      if (mem_sel[i]) mem_dout = arr[i];
  end

  typedef struct packed {
    logic       we;
    logic [2:0] addr;
    logic [7:0] wdata;
  } op_t;

  typedef struct {
    bit  r;
    op_t op;
  } ex_t;

  typedef struct {
    bit         r;
    bit         we;
    logic [2:0] addr;
    logic [7:0] wd;
    int         lat;
    logic [7:0] sel;
    logic [7:0] rd;
  } vec_t;

  int total = 0;
  int bad = 0;
  bit mlast = 1;
  logic [7:0] refm [8];
  op_t q0[$], q1[$];
  ex_t exq[$];
  vec_t tbl[9];

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic op_t mk(bit we, int a, int d);
    op_t o;
    o.we = we;
    o.addr = 3'(a);
    o.wdata = 8'(d);
    return o;
  endfunction

  function automatic int lat_of(op_t o);
    return o.we ? 2 + WR : 3;
  endfunction

  // transaction-level round robin: free requester wins, ties alternate
  function automatic void build_exp();
    op_t a[$];
    op_t b[$];
    ex_t e;
    a = q0;
    b = q1;
    exq.delete();
    while (a.size() > 0 || b.size() > 0) begin
      if (a.size() > 0 && b.size() > 0) e.r = ~mlast;
      else e.r = (b.size() > 0);
      e.op = e.r ? b.pop_front() : a.pop_front();
      mlast = e.r;
      exq.push_back(e);
    end
  endfunction

  task automatic drive(bit r, op_t o);
    if (r) begin
      req1 = 1; we1 = o.we; addr1 = o.addr; wdata1 = o.wdata;
    end else begin
      req0 = 1; we0 = o.we; addr0 = o.addr; wdata0 = o.wdata;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1;
    repeat (2) @(negedge clk);
    chk("rst_sel", mem_sel, 0);
    chk("rst_rw", mem_rw, 1);
    chk("rst_din", mem_din, 0);
    chk("rst_acks", {ack1, ack0}, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_busy", busy, 0);
    rst = 0;
    mlast = 1;
  endtask

  task automatic do_op(input bit r, input op_t o, output int lat,
                       output int ackr, output int selc,
                       output logic [7:0] selv, output logic [7:0] rd);
    int start;
    @(negedge clk);
    drive(r, o);
    start = cyc;
    lat = -1; ackr = -1; selc = 0; selv = 0; rd = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mem_sel != 0) begin
        selc++;
        selv = mem_sel;
      end
      if (ack0 || ack1) begin
        lat = cyc - start;
        ackr = ack1 ? 1 : 0;
        rd = rdata;
        break;
      end
    end
    req0 = 0;
    req1 = 0;
    mlast = r;
    if (o.we) refm[o.addr] = o.wdata;
  endtask

  task automatic run_batch();
    int n, idx, start, prev, tgt, guard;
    bit r;
    op_t o;
    build_exp();
    n = exq.size();
    @(negedge clk);
    if (q0.size() > 0) drive(0, q0[0]);
    if (q1.size() > 0) drive(1, q1[0]);
    start = cyc;
    prev = 0;
    idx = 0;
    guard = 0;
    while (idx < n && guard < 200) begin
      @(negedge clk);
      guard++;
      if (ack0 || ack1) begin
        r = ack1;
        o = exq[idx].op;
        tgt = (idx == 0) ? start + lat_of(o) : prev + 1 + lat_of(o);
        chk("order", r, exq[idx].r);
        chk("ack_time", cyc, tgt);
        if (!o.we) chk("rdata", rdata, refm[o.addr]);
        else refm[o.addr] = o.wdata;
        prev = cyc;
        idx++;
        if (r) begin
          if (q1.size() > 0) void'(q1.pop_front());
          if (q1.size() > 0) drive(1, q1[0]);
          else req1 = 0;
        end else begin
          if (q0.size() > 0) void'(q0.pop_front());
          if (q0.size() > 0) drive(0, q0[0]);
          else req0 = 0;
        end
      end
    end
    if (idx < n) chk("batch_timeout", idx, n);
    req0 = 0;
    req1 = 0;
    q0.delete();
    q1.delete();
  endtask

  initial begin
    int lat, ackr, selc;
    logic [7:0] selv, rd;
    logic prev_rw;
    logic [7:0] prev_din;

    tbl[0] = '{0, 1, 5, 8'hA5, 4, 8'h20, 8'h00};
    tbl[1] = '{0, 0, 5, 8'h00, 3, 8'h20, 8'hA5};
    tbl[2] = '{1, 1, 0, 8'hFF, 4, 8'h01, 8'h00};
    tbl[3] = '{1, 1, 7, 8'h00, 4, 8'h80, 8'h00};
    tbl[4] = '{0, 1, 0, 8'h00, 4, 8'h01, 8'h00};
    tbl[5] = '{0, 1, 7, 8'hFF, 4, 8'h80, 8'h00};
    tbl[6] = '{1, 0, 0, 8'h00, 3, 8'h01, 8'h00};
    tbl[7] = '{0, 0, 7, 8'h00, 3, 8'h80, 8'hFF};
    tbl[8] = '{1, 0, 5, 8'h00, 3, 8'h20, 8'hA5};

    // per-cycle invariants: one row at most, one ack at most,
    // RW/Din frozen while any row is selected
    prev_rw = 1;
    prev_din = 0;
    fork
      forever begin
        @(negedge clk);
        chk("onehot", int'($countones(mem_sel) <= 1), 1);
        chk("ack_excl", int'(ack0 && ack1), 0);
        if (mem_sel != 0) begin
          chk("rw_stable", mem_rw, prev_rw);
          chk("din_stable", mem_din, prev_din);
        end
        prev_rw = mem_rw;
        prev_din = mem_din;
      end
    join_none

    do_reset();

    foreach (tbl[i]) begin
      do_op(tbl[i].r, mk(tbl[i].we, tbl[i].addr, tbl[i].wd),
            lat, ackr, selc, selv, rd);
      chk($sformatf("v%0d_lat", i), lat, tbl[i].lat);
      chk($sformatf("v%0d_ack", i), ackr, tbl[i].r);
      chk($sformatf("v%0d_selc", i), selc, tbl[i].we ? WR : 1);
      chk($sformatf("v%0d_selv", i), selv, tbl[i].sel);
      if (!tbl[i].we) chk($sformatf("v%0d_rd", i), rd, tbl[i].rd);
    end

    // simultaneous requests straight after reset: req0 first
    do_reset();
    q0.push_back(mk(1, 1, 8'h11));
    q1.push_back(mk(1, 2, 8'h22));
    run_batch();
    q0.push_back(mk(0, 1, 0));
    q1.push_back(mk(0, 2, 0));
    run_batch();

    // both held for six accesses: strict alternation
    q0.push_back(mk(1, 4, 8'h44));
    q0.push_back(mk(0, 1, 0));
    q0.push_back(mk(1, 6, 8'h66));
    q1.push_back(mk(0, 2, 0));
    q1.push_back(mk(1, 3, 8'h33));
    q1.push_back(mk(0, 4, 0));
    run_batch();

    // reset in the first ACCESS cycle of a write
    @(negedge clk);
    drive(0, mk(1, 3, 8'h5A));
    @(negedge clk);
    chk("t6_setup_sel", mem_sel, 0);
    chk("t6_setup_rw", mem_rw, 0);
    chk("t6_setup_din", mem_din, 8'h5A);
    @(negedge clk);
    chk("t6_acc_sel", mem_sel, 8'h08);
    rst = 1;
    req0 = 0;
    @(negedge clk);
    chk("t6_rst_sel", mem_sel, 0);
    chk("t6_rst_rw", mem_rw, 1);
    chk("t6_rst_din", mem_din, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_ack", {ack1, ack0}, 0);
    rst = 0;
    mlast = 1;
    @(negedge clk);
    chk("t6_no_ack", {ack1, ack0}, 0);
    do_op(1, mk(0, 5, 0), lat, ackr, selc, selv, rd);
    chk("t6_rd_lat", lat, 3);
    chk("t6_rd_ack", ackr, 1);
    chk("t6_rd_data", rd, 8'hA5);

    // give every row a known value, then random batches
    for (int a = 0; a < 8; a++) begin
      do_op(a[0], mk(1, a, 8'(a * 37 + 3)), lat, ackr, selc, selv, rd);
      chk("init_lat", lat, 2 + WR);
    end
    for (int b = 0; b < 30; b++) begin
      int mode, n0, n1;
      mode = $urandom_range(0, 2);
      n0 = (mode != 1) ? $urandom_range(1, 3) : 0;
      n1 = (mode != 0) ? $urandom_range(1, 3) : 0;
      for (int i = 0; i < n0; i++)
        q0.push_back(mk($urandom_range(0, 1), $urandom_range(0, 7),
                        $urandom_range(0, 255)));
      for (int i = 0; i < n1; i++)
        q1.push_back(mk($urandom_range(0, 1), $urandom_range(0, 7),
                        $urandom_range(0, 255)));
      run_batch();
    end

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
